// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit oversampled sampling.
//
// The RX pin is brought into the clock domain through a two-flop synchronizer.
// A falling edge on the synchronized line starts a frame. The start bit is
// re-checked at its midpoint to reject glitches. Each of the eight data bits
// (LSB first) and the stop bit are then sampled one bit period apart. A good
// stop bit publishes the byte. A low stop bit reports a framing error and
// parks the receiver until the line returns high.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   rx            serial input, asynchronous to clk, idles high
//   rx_valid      one-cycle pulse, rx_data holds a new byte
//   rx_data       last good byte, stable until the next rx_valid
//   rx_frame_err  one-cycle pulse, stop bit was sampled low
//   rx_active     high whenever the receiver is not idle

`timescale 1ns/1ps

module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_frame_err,
   output logic       rx_active
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

   // Compare values; both fit in CNT_W bits, so the counter never wraps early.
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   // Synchronizer and edge-detect history. Reset high so that reset
   // release on an idle line never looks like a start edge.
   logic rx_meta;
   logic rx_s;
   logic rx_s_prev;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_s_prev <= 1'b1;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         rx_s_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx_s && rx_s_prev) begin
               state_d = StStart;
            end
         end

         StStart: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               // A line already back high at mid start bit was a glitch.
               state_d = rx_s ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StData: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               // Right shift: bit 0 enters first and ends up in shift_q[0].
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StStop: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StBreak: begin
            // Level, not edge: any high line ends the break.
            cnt_d = '0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase
   end

   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_data      = data_q;
   assign rx_active    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: random-ish 8N1 frames driven on rx, expected bytes and
// arrival cycles queued by the driver, checked by an independent monitor.

`timescale 1ns/1ps

module tb_uart_rx;

   localparam int unsigned CPB    = 8;
   localparam int          LAT    = 2 + CPB / 2 + 9 * CPB;  // 78 cycles from sampled edge
   localparam real         BIT_NS = CPB * 10.0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_frame_err;
   logic       rx_active;

   uart_rx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_frame_err (rx_frame_err),
      .rx_active    (rx_active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      int         at;
      bit         err;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] last_good   = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one frame starting now. The first posedge after the falling edge
   // is E; the response is due LAT cycles after E.
   task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_bit,
                             input bit expect_it);
      exp_t e;
      e.data = b;
      e.at   = cyc + 1 + LAT;
      e.err  = !stop_bit;
      if (expect_it) exp_q.push_back(e);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop_bit;
      #(bit_ns);
   endtask

   // Monitor: every output pulse must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_frame_err) begin
            check("valid_and_err_together", 32'(rx_frame_err), 32'd0);
         end else if (rx_valid || rx_frame_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {30'd0, rx_valid, rx_frame_err}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("pulse_kind_err", 32'(rx_frame_err), 32'(e.err));
               check("pulse_cycle", 32'(cyc), 32'(e.at));
               if (e.err) begin
                  check("data_kept_on_err", 32'(rx_data), 32'(last_good));
               end else begin
                  check("rx_data", 32'(rx_data), 32'(e.data));
                  last_good = e.data;
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] b;

      // Reset state.
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(rx_valid), 32'd0);
      check("reset_ferr", 32'(rx_frame_err), 32'd0);
      check("reset_data", 32'(rx_data), 32'd0);
      check("reset_active", 32'(rx_active), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_active", 32'(rx_active), 32'd0);

      // Single byte.
      send_frame(8'h35, BIT_NS, 1'b1, 1'b1);
      repeat (10) @(negedge clk);

      // Back-to-back, no idle between frames.
      send_frame(8'h31, BIT_NS, 1'b1, 1'b1);
      send_frame(8'h32, BIT_NS, 1'b1, 1'b1);
      send_frame(8'h0A, BIT_NS, 1'b1, 1'b1);
      repeat (10) @(negedge clk);

      // Random bytes, some back-to-back.
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, BIT_NS, 1'b1, 1'b1);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 15)) @(negedge clk);
      end
      repeat (10) @(negedge clk);

      // Glitch: 3 cycles low is rejected at the start-bit midpoint.
      rx = 1'b0;
      repeat (3) @(negedge clk);
      check("glitch_active_start", 32'(rx_active), 32'd1);
      rx = 1'b1;
      repeat (12) @(negedge clk);
      check("glitch_back_idle", 32'(rx_active), 32'd0);
      send_frame(8'hA5, BIT_NS, 1'b1, 1'b1);
      repeat (10) @(negedge clk);

      // Framing error followed by a held-low line.
      send_frame(8'h55, BIT_NS, 1'b0, 1'b1);
      repeat (40) @(negedge clk);
      check("break_active", 32'(rx_active), 32'd1);
      check("break_data_kept", 32'(rx_data), 32'h A5);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      check("break_released", 32'(rx_active), 32'd0);
      send_frame(8'h42, BIT_NS, 1'b1, 1'b1);
      repeat (10) @(negedge clk);

      // Reset during data bit 3 of 0xFF.
      @(negedge clk);
      fork
         send_frame(8'hFF, BIT_NS, 1'b1, 1'b0);
         begin
            #(4.0 * BIT_NS + 40.0);
            check("mid_frame_active", 32'(rx_active), 32'd1);
            rst = 1'b1;
            #3;
            check("mid_rst_active", 32'(rx_active), 32'd0);
            check("mid_rst_data", 32'(rx_data), 32'd0);
            check("mid_rst_valid", 32'(rx_valid), 32'd0);
            last_good = 8'h00;
            #20;
            rst = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check("post_rst_data", 32'(rx_data), 32'd0);
      send_frame(8'h0F, BIT_NS, 1'b1, 1'b1);
      repeat (10) @(negedge clk);

      // Baud skew of -3% and +3%.
      send_frame(8'h5A, 77.6, 1'b1, 1'b1);
      send_frame(8'hC3, 77.6, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      send_frame(8'h5A, 82.4, 1'b1, 1'b1);
      send_frame(8'hC3, 82.4, 1'b1, 1'b1);
      repeat (100) @(negedge clk);

      check("all_expected_seen", 32'(exp_q.size()), 32'd0);
      check("final_idle", 32'(rx_active), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
